// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, baud divisor helper and
// host command bytes used by the sensor crossbar.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] CMD_TEMP = 8'h54;
    localparam logic [7:0] CMD_DIST = 8'h44;

    // Integer clocks per bit; the fractional remainder is dropped.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers. A full FIFO refuses a push even
// when a pop happens on the same edge. Shared with the future RX path.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_en;
    logic             pop_en;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; both wrap modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART 8N1 transmitter fed from a byte FIFO. Absorbs crossbar bursts
// (DHT11 / HC-SR04 frames) and streams them back-to-back at the line rate.
module uart_tx_serializer #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    import uart_pkg::*;

    localparam int              CPB      = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int              CNT_W    = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

    tx_state_t        state;
    tx_state_t        state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_done;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rd;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_ready = !fifo_full;
    assign bit_done = (baud_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and FIFO pop; STOP pops straight into START so frames abut.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) state_next = DATA;
            end
            DATA: begin
                if (bit_done && (bit_idx == 3'd7)) state_next = STOP;
            end
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Baud counter, bit index and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            if ((state == IDLE) || (state_next != state) || bit_done) baud_cnt <= '0;
            else                                                      baud_cnt <= baud_cnt + 1'b1;

            if (fifo_pop)                      shreg <= fifo_rd;
            else if ((state == DATA) && bit_done) shreg <= {1'b0, shreg[7:1]};

            if (state != DATA) bit_idx <= '0;
            else if (bit_done) bit_idx <= bit_idx + 3'd1;
        end
    end

    // Output registers; txd trails the state by one cycle, hence push-to-start latency of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd      <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                START:   txd <= 1'b0;
                DATA:    txd <= shreg[0];
                default: txd <= 1'b1;
            endcase
            busy     <= (state != IDLE) || !fifo_empty;
            overflow <= in_valid && fifo_full;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: directed scenarios plus random traffic against
// a time-based line model (frame countdown + byte queue) and a serial decoder.
module tb_uart_tx_serializer;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD_R = 100_000;
    localparam int DEPTH  = 4;
    localparam int CPB    = 10;
    localparam int FRAME  = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_level;
    logic       overflow;

    uart_tx_serializer #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_R),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queued bytes, cycles left on the current frame, and
    // the byte being sent. Registered outputs are predicted from pre-edge values.
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    int         line_cnt = 0;
    logic [7:0] cur_byte = 8'h00;
    logic       exp_txd  = 1'b1;
    logic       exp_busy = 1'b0;
    logic       exp_ovf  = 1'b0;
    int         edge_n   = 0;

    // Serial decoder state.
    bit         dec_active = 1'b0;
    int         dec_cnt    = 0;
    logic [7:0] dec_byte   = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[slot-1];
    endfunction

    task automatic model_reset();
        mq.delete();
        sent_q.delete();
        line_cnt   = 0;
        exp_txd    = 1'b1;
        exp_busy   = 1'b0;
        exp_ovf    = 1'b0;
        dec_active = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d);
        bit do_push;
        bit do_pop;
        if (rst) begin
            model_reset();
            return;
        end
        exp_txd  = (line_cnt > 0) ? frame_bit(cur_byte, (FRAME - line_cnt) / CPB) : 1'b1;
        exp_busy = (line_cnt > 0) || (mq.size() > 0);
        exp_ovf  = v && (mq.size() == DEPTH);
        do_push  = v && (mq.size() < DEPTH);
        do_pop   = (mq.size() > 0) && (line_cnt <= 1);
        if (do_pop) begin
            cur_byte = mq.pop_front();
            sent_q.push_back(cur_byte);
            line_cnt = FRAME;
        end else if (line_cnt > 0) begin
            line_cnt--;
        end
        if (do_push) mq.push_back(d);
    endtask

    task automatic check_outputs();
        logic [31:0] want;
        chk("txd", txd, exp_txd);
        chk("busy", busy, exp_busy);
        chk("overflow", overflow, exp_ovf);
        chk("fifo_level", fifo_level, mq.size());
        chk("in_ready", in_ready, mq.size() < DEPTH);
        if (!rst) begin
            if (!dec_active) begin
                if (txd === 1'b0) begin
                    dec_active = 1'b1;
                    dec_cnt    = 0;
                end
            end else begin
                dec_cnt++;
                if ((dec_cnt % CPB == CPB/2) && (dec_cnt / CPB >= 1) && (dec_cnt / CPB <= 8))
                    dec_byte[dec_cnt/CPB - 1] = txd;
                if (dec_cnt == 9*CPB + CPB/2) begin
                    chk("stop_bit", txd, 1'b1);
                    if (sent_q.size() > 0) want = {24'd0, sent_q.pop_front()};
                    else                   want = 32'h100;
                    chk("decoded_byte", {24'd0, dec_byte}, want);
                    dec_active = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        edge_n++;
        model_edge(v, d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk({tag, "_txd_async"}, txd, 1'b1);
        chk({tag, "_level_async"}, fifo_level, 3'd0);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int t_low;
        int t_idle;
        int thr;
        bit v;

        @(negedge clk);
        check_outputs();

        // Reset held for three cycles, then a quiet gap.
        repeat (3) cycle(1'b0, 8'h00);
        rst = 1'b0;
        repeat (2) cycle(1'b0, 8'h00);

        // Single byte: start bit two edges after the push, busy for 100 cycles.
        cycle(1'b1, 8'h54);
        n      = edge_n;
        t_low  = -1;
        t_idle = -1;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 8'h00);
            if (t_low < 0 && txd === 1'b0) t_low = edge_n;
            if (t_low >= 0 && t_idle < 0 && busy === 1'b0) t_idle = edge_n;
        end
        chk("s2_latency", t_low - n, 2);
        chk("s2_busy_len", t_idle - t_low, FRAME);

        // Back-to-back bytes.
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h3C);
        repeat (220) cycle(1'b0, 8'h00);

        // Fill and overflow: six pushes, five accepted.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom));
        chk("s4_in_ready", in_ready, 1'b0);
        chk("s4_overflow", overflow, 1'b1);

        // Push on the STOP->START pop edge while full: refused.
        for (int i = 0; i < 200 && line_cnt != 1; i++) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'hEE);
        chk("s5_level", fifo_level, 3'd3);
        chk("s5_overflow", overflow, 1'b1);
        repeat (450) cycle(1'b0, 8'h00);

        // Reset during data bit 3, then a fresh byte.
        cycle(1'b1, 8'hF0);
        for (int i = 0; i < 200 && line_cnt != FRAME - 45; i++) cycle(1'b0, 8'h00);
        chk("s6_txd_before_rst", txd, 1'b0);
        async_reset_pulse("s6");
        cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h44);
        repeat (120) cycle(1'b0, 8'h00);

        // Random traffic with varying load and one asynchronous reset.
        thr = 20;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) thr = $urandom_range(0, 60);
            v = ($urandom_range(0, 99) < thr);
            cycle(v, 8'($urandom));
            if (i == 2500) async_reset_pulse("rand_rst");
        end
        repeat (600) cycle(1'b0, 8'h00);
        chk("final_idle_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
